// File: rtl/vtw_vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// vtw_vector_sequencer_if : control, vector-record and status bundle for the
// vector sequencer.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vtw_vector_sequencer_if #(
  parameter int NUM_TRIG = 7,
  parameter int PERIOD_W = 16,
  parameter int REP_W    = 16
);
  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period;
  logic                vec_valid;
  logic                vec_ready;
  logic [NUM_TRIG-1:0] vec_trig_mask;
  logic [REP_W-1:0]    vec_repeat;
  logic                vec_last;
  logic [NUM_TRIG-1:0] triggers;
  logic [31:0]         vector_number;
  logic [31:0]         cycle_number;
  logic                busy;
  logic                done;
  logic                underrun;

  modport master (
    output start, stop, period, vec_valid, vec_trig_mask, vec_repeat, vec_last,
    input  vec_ready, triggers, vector_number, cycle_number, busy, done, underrun
  );

  modport slave (
    input  start, stop, period, vec_valid, vec_trig_mask, vec_repeat, vec_last,
    output vec_ready, triggers, vector_number, cycle_number, busy, done, underrun
  );
endinterface

`default_nettype wire

// File: rtl/vtw_vector_sequencer.sv
// ---------------------------------------------------------------------------
// vtw_vector_sequencer : plays vector records as tester cycles, pulsing the
// waveform-generator triggers at each cycle start.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vtw_vector_sequencer #(
  parameter int NUM_TRIG = 7,
  parameter int PERIOD_W = 16,
  parameter int REP_W    = 16
) (
  input  wire                  clk,
  input  wire                  rst_n,
  vtw_vector_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_ticks;
  logic [REP_W-1:0]    r_rep;
  logic [NUM_TRIG-1:0] r_mask;
  logic                r_last;
  logic                r_first;
  logic                r_any;
  logic                r_was_fetch;
  logic                r_underrun;
  logic                r_abort_done;
  logic [31:0]         r_vec_num;
  logic [31:0]         r_cyc_num;

  logic                w_ready;
  logic                w_transfer;
  logic                w_final;
  logic                w_reload;
  logic                w_start;
  logic                w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    w_ready    = 1'b0;
    w_transfer = 1'b0;
    w_final    = 1'b0;
    w_reload   = 1'b0;
    w_start    = 1'b0;
    w_abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          w_start   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // stop wins over a pending transfer, so ready is withdrawn under stop
        w_ready = ~bus.stop;
        if (bus.stop) begin
          w_abort   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.vec_valid) begin
          w_transfer = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        w_final = (r_ticks == '0);
        if (bus.stop) begin
          w_abort   = 1'b1;
          state_nxt = S_IDLE;
        end else if (w_final) begin
          if (r_rep != '0) begin
            w_reload = 1'b1;
          end else if (r_last) begin
            state_nxt = S_DONE;
          end else begin
            w_ready = 1'b1;
            if (bus.vec_valid) w_transfer = 1'b1;
            else               state_nxt  = S_FETCH;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period     <= '0;
      r_ticks      <= '0;
      r_rep        <= '0;
      r_mask       <= '0;
      r_last       <= 1'b0;
      r_first      <= 1'b0;
      r_any        <= 1'b0;
      r_was_fetch  <= 1'b0;
      r_underrun   <= 1'b0;
      r_abort_done <= 1'b0;
      r_vec_num    <= '0;
      r_cyc_num    <= '0;
    end else begin
      r_first      <= 1'b0;
      r_was_fetch  <= (state == S_FETCH);
      r_abort_done <= w_abort;
      if (w_start) begin
        r_period   <= (bus.period == '0) ? PERIOD_W'(1) : bus.period;
        r_underrun <= 1'b0;
        r_vec_num  <= '0;
        r_cyc_num  <= '0;
        r_any      <= 1'b0;
      end
      // the first FETCH clock is a grace clock; starvation counts after it
      if (state == S_FETCH && r_was_fetch && !bus.vec_valid && !bus.stop)
        r_underrun <= 1'b1;
      if (w_transfer) begin
        r_mask  <= bus.vec_trig_mask;
        r_rep   <= bus.vec_repeat;
        r_last  <= bus.vec_last;
        r_ticks <= r_period - PERIOD_W'(1);
        r_first <= 1'b1;
        r_any   <= 1'b1;
        if (r_any) begin
          r_vec_num <= r_vec_num + 32'd1;
          r_cyc_num <= r_cyc_num + 32'd1;
        end
      end else if (w_reload) begin
        r_rep     <= r_rep - REP_W'(1);
        r_ticks   <= r_period - PERIOD_W'(1);
        r_first   <= 1'b1;
        r_cyc_num <= r_cyc_num + 32'd1;
      end else if (state == S_RUN && !w_final) begin
        r_ticks <= r_ticks - PERIOD_W'(1);
      end
    end
  end

  assign bus.vec_ready     = w_ready;
  assign bus.triggers      = (state == S_RUN && r_first && !bus.stop) ? r_mask : '0;
  assign bus.busy          = (state == S_FETCH) || (state == S_RUN);
  assign bus.done          = (state == S_DONE) || r_abort_done;
  assign bus.underrun      = r_underrun;
  assign bus.vector_number = r_vec_num;
  assign bus.cycle_number  = r_cyc_num;

endmodule

`default_nettype wire

// File: tb/tb_vtw_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vtw_vector_sequencer : table-driven per-clock checks plus reset sequence.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vtw_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vtw_vector_sequencer_if #(.NUM_TRIG(7), .PERIOD_W(16), .REP_W(16)) bus ();

  vtw_vector_sequencer #(.NUM_TRIG(7), .PERIOD_W(16), .REP_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          start;
    bit          stop;
    bit          valid;
    logic [6:0]  mask;
    logic [15:0] rep;
    bit          last;
    logic [15:0] period;
    logic [6:0]  e_trig;
    bit          e_ready;
    bit          e_busy;
    bit          e_done;
    bit          e_under;
    int          e_vn;
    int          e_cn;
  } row_t;

  row_t rows[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(bit s, bit p, bit v, logic [6:0] m, logic [15:0] r, bit l,
                              logic [15:0] per, logic [6:0] t, bit rdy, bit b, bit d,
                              bit u, int vn, int cn);
    row_t x;
    x.start = s; x.stop = p; x.valid = v; x.mask = m; x.rep = r; x.last = l;
    x.period = per; x.e_trig = t; x.e_ready = rdy; x.e_busy = b; x.e_done = d;
    x.e_under = u; x.e_vn = vn; x.e_cn = cn;
    rows.push_back(x);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_trig"},  32'(bus.triggers),  32'd0);
    chk({tag, "_ready"}, 32'(bus.vec_ready), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
    chk({tag, "_under"}, 32'(bus.underrun),  32'd0);
    chk({tag, "_vn"},    bus.vector_number,  32'd0);
    chk({tag, "_cn"},    bus.cycle_number,   32'd0);
  endtask

  initial begin
    int   n;
    logic [6:0] acc;
    logic       busy_seen;

    bus.start = 0; bus.stop = 0; bus.period = '0; bus.vec_valid = 0;
    bus.vec_trig_mask = '0; bus.vec_repeat = '0; bus.vec_last = 0;

    // three vectors, period 4
    add(1,0,1,7'h01,0,0,4, 7'h00,0,0,0,0,0,0);
    add(0,0,1,7'h01,0,0,4, 7'h00,1,1,0,0,0,0);
    add(0,0,1,7'h06,0,0,4, 7'h01,0,1,0,0,0,0);
    add(0,0,1,7'h06,0,0,4, 7'h00,0,1,0,0,0,0);
    add(0,0,1,7'h06,0,0,4, 7'h00,0,1,0,0,0,0);
    add(0,0,1,7'h06,0,0,4, 7'h00,1,1,0,0,0,0);
    add(0,0,1,7'h78,0,1,4, 7'h06,0,1,0,0,1,1);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,1,0,0,1,1);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,1,0,0,1,1);
    add(0,0,1,7'h78,0,1,4, 7'h00,1,1,0,0,1,1);
    add(0,0,1,7'h78,0,1,4, 7'h78,0,1,0,0,2,2);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,1,0,0,2,2);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,1,0,0,2,2);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,1,0,0,2,2);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,0,1,0,2,2);
    add(0,0,1,7'h78,0,1,4, 7'h00,0,0,0,0,2,2);
    // one vector replayed, period 3; start while busy is ignored
    add(1,0,1,7'h05,2,1,3, 7'h00,0,0,0,0,2,2);
    add(0,0,1,7'h05,2,1,3, 7'h00,1,1,0,0,0,0);
    add(0,0,0,7'h05,2,1,3, 7'h05,0,1,0,0,0,0);
    add(1,0,0,7'h05,2,1,3, 7'h00,0,1,0,0,0,0);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,1,0,0,0,0);
    add(0,0,0,7'h05,2,1,3, 7'h05,0,1,0,0,0,1);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,1,0,0,0,1);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,1,0,0,0,1);
    add(0,0,0,7'h05,2,1,3, 7'h05,0,1,0,0,0,2);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,1,0,0,0,2);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,1,0,0,0,2);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,0,1,0,0,2);
    add(0,0,0,7'h05,2,1,3, 7'h00,0,0,0,0,0,2);
    // period 0 behaves as 1
    add(1,0,1,7'h7F,1,1,0, 7'h00,0,0,0,0,0,2);
    add(0,0,1,7'h7F,1,1,0, 7'h00,1,1,0,0,0,0);
    add(1,0,0,7'h7F,1,1,0, 7'h7F,0,1,0,0,0,0);
    add(0,0,0,7'h7F,1,1,0, 7'h7F,0,1,0,0,0,1);
    add(0,0,0,7'h7F,1,1,0, 7'h00,0,0,1,0,0,1);
    add(0,0,0,7'h7F,1,1,0, 7'h00,0,0,0,0,0,1);
    // starvation gap of five clocks, period 2
    add(1,0,1,7'h03,0,0,2, 7'h00,0,0,0,0,0,1);
    add(0,0,1,7'h03,0,0,2, 7'h00,1,1,0,0,0,0);
    add(0,0,0,7'h03,0,0,2, 7'h03,0,1,0,0,0,0);
    add(0,0,0,7'h03,0,0,2, 7'h00,1,1,0,0,0,0);
    add(0,0,0,7'h03,0,0,2, 7'h00,1,1,0,0,0,0);
    add(0,0,0,7'h03,0,0,2, 7'h00,1,1,0,0,0,0);
    add(0,0,0,7'h03,0,0,2, 7'h00,1,1,0,1,0,0);
    add(0,0,0,7'h03,0,0,2, 7'h00,1,1,0,1,0,0);
    add(0,0,1,7'h40,0,1,2, 7'h00,1,1,0,1,0,0);
    add(0,0,0,7'h40,0,1,2, 7'h40,0,1,0,1,1,1);
    add(0,0,0,7'h40,0,1,2, 7'h00,0,1,0,1,1,1);
    add(0,0,0,7'h40,0,1,2, 7'h00,0,0,1,1,1,1);
    add(0,0,0,7'h40,0,1,2, 7'h00,0,0,0,1,1,1);
    // stop on second clock of a period-8 cycle
    add(1,0,1,7'h11,0,0,8, 7'h00,0,0,0,1,1,1);
    add(0,0,1,7'h11,0,0,8, 7'h00,1,1,0,0,0,0);
    add(0,0,1,7'h11,0,0,8, 7'h11,0,1,0,0,0,0);
    add(0,1,1,7'h11,0,0,8, 7'h00,0,1,0,0,0,0);
    add(0,0,1,7'h11,0,0,8, 7'h00,0,0,1,0,0,0);
    add(0,0,1,7'h11,0,0,8, 7'h00,0,0,0,0,0,0);
    add(0,0,1,7'h11,0,0,8, 7'h00,0,0,0,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (rows[i]) begin
      bus.start         = rows[i].start;
      bus.stop          = rows[i].stop;
      bus.vec_valid     = rows[i].valid;
      bus.vec_trig_mask = rows[i].mask;
      bus.vec_repeat    = rows[i].rep;
      bus.vec_last      = rows[i].last;
      bus.period        = rows[i].period;
      @(negedge clk);
      chk($sformatf("row%0d_trig", i),  32'(bus.triggers),  32'(rows[i].e_trig));
      chk($sformatf("row%0d_ready", i), 32'(bus.vec_ready), 32'(rows[i].e_ready));
      chk($sformatf("row%0d_busy", i),  32'(bus.busy),      32'(rows[i].e_busy));
      chk($sformatf("row%0d_done", i),  32'(bus.done),      32'(rows[i].e_done));
      chk($sformatf("row%0d_under", i), 32'(bus.underrun),  32'(rows[i].e_under));
      chk($sformatf("row%0d_vn", i),    bus.vector_number,  rows[i].e_vn);
      chk($sformatf("row%0d_cn", i),    bus.cycle_number,   rows[i].e_cn);
      @(posedge clk);
      #1;
    end

    // reset asserted mid-run while the second vector plays, period 5
    bus.stop = 0; bus.period = 16'd5; bus.vec_valid = 1; bus.vec_trig_mask = 7'h2A;
    bus.vec_repeat = '0; bus.vec_last = 0; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    @(posedge clk); #1;
    bus.vec_trig_mask = 7'h15; bus.vec_last = 1;
    n = 0;
    while (bus.triggers !== 7'h15 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_seq_second_vector_seen", 32'(n < 30), 32'd1);
    chk("rst_seq_vn_before", bus.vector_number, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    acc = '0;
    busy_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      acc = acc | bus.triggers;
      busy_seen = busy_seen | bus.busy;
    end
    chk("no_trig_after_reset", 32'(acc), 32'd0);
    chk("no_busy_after_reset", 32'(busy_seen), 32'd0);

    bus.vec_trig_mask = 7'h2A; bus.vec_last = 1; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    n = 0;
    while (bus.triggers === 7'h00 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_trig", 32'(bus.triggers), 32'h2A);
    chk("restart_vn", bus.vector_number, 32'd0);
    chk("restart_cn", bus.cycle_number, 32'd0);
    n = 0;
    while (bus.done !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_done_seen", 32'(bus.done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
